async_fifo_rd_ctrl: RTL and testbench

Read-domain half of the dual-clock FIFO. It runs entirely on rd_clk and drives the read port of async_ram_1r1w (LATENCY=1). It synchronises the write-side Gray pointer, detects RAM-empty and issues RAM reads. It absorbs the one-cycle RAM read latency in a 2-entry output buffer, presents a valid/ready stream at full throughput, and exports the registered Gray read pointer to the write-domain controller.

---
 rtl/async_fifo_rd_ctrl_pkg.sv | 30 +++
 rtl/async_fifo_rd_ctrl_if.sv | 28 ++
 rtl/async_fifo_rd_ctrl_ptr_sync.sv | 33 +++
 rtl/async_fifo_rd_ctrl.sv | 121 ++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_rd_ctrl_pkg
//  Purpose  : Shared constants and Gray/binary helpers for the dual-clock FIFO
//  Revision : 1.0  initial release
// ============================================================================
package async_fifo_rd_ctrl_pkg;

    localparam int OBUF_DEPTH = 2;
    localparam int PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Operate on a zero-extended word so callers of any width up to
    // PTR_MAX_W get the correct result after truncating back.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_rd_ctrl_if
//  Purpose  : RAM read port and output valid/ready stream of the read side
//  Revision : 1.0  initial release
// ============================================================================
interface async_fifo_rd_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          ram_rd;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        output ram_rd, ram_raddr, m_valid, m_data,
        input  ram_rdata, m_ready
    );

    modport slave (
        input  ram_rd, ram_raddr, m_valid, m_data,
        output ram_rdata, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo_rd_ctrl_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ptr_sync
//  Purpose  : Multi-flop synchroniser for a Gray-coded pointer
//  Revision : 1.0  initial release
// ============================================================================
module ptr_sync #(
    parameter int W      = 11,
    parameter int STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] d,
    output logic      [W-1:0] q
);
    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_rd_ctrl
//  Purpose  : Read-domain controller of the dual-clock FIFO with 2-entry skid
//  Revision : 1.0  initial release
// ============================================================================
module async_fifo_rd_ctrl
    import async_fifo_rd_ctrl_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 10,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          rd_clk,
    input  wire logic          rrstn,
    input  wire logic [AW:0]   wptr_gray,
    output logic      [AW:0]   rptr_gray,
    output logic               empty,
    output logic      [AW:0]   rd_level,
    async_fifo_rd_ctrl_if.master bus
);
    localparam int PW = AW + 1;

    logic [AW:0]   w_wgray_s;
    logic [AW:0]   w_wbin_s;
    logic [AW:0]   w_rbin_nxt;
    logic          w_ram_empty;
    logic          w_pop;
    logic          w_load;
    logic          w_issue;
    logic [1:0]    w_credit;

    logic [AW:0]   r_rbin;
    logic [AW:0]   r_rptr_gray;
    logic [AW:0]   r_pop_cnt;
    logic [AW:0]   r_rd_level;
    logic          r_inflight;
    logic [1:0]    r_count;
    logic [DW-1:0] r_buf [OBUF_DEPTH];

    ptr_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk    (rd_clk),
        .rst_n  (rrstn),
        .d      (wptr_gray),
        .q      (w_wgray_s)
    );

    assign w_wbin_s    = PW'(gray2bin(ptr_word_t'(w_wgray_s)));
    assign w_rbin_nxt  = r_rbin + PW'(1);
    assign w_ram_empty = (r_rbin == w_wbin_s);
    assign w_pop       = bus.m_valid & bus.m_ready;
    assign w_load      = r_inflight;
    // Words already owned by the output side: buffered plus the one in the RAM pipe.
    assign w_credit    = r_count + {1'b0, r_inflight};
    assign w_issue     = !w_ram_empty &&
                         ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop));

    always_ff @(posedge rd_clk or negedge rrstn) begin
        if (!rrstn) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_inflight  <= 1'b0;
            r_pop_cnt   <= '0;
            r_rd_level  <= '0;
        end else begin
            if (w_issue) begin
                r_rbin      <= w_rbin_nxt;
                r_rptr_gray <= PW'(bin2gray(ptr_word_t'(w_rbin_nxt)));
            end
            r_inflight <= w_issue;
            r_pop_cnt  <= r_pop_cnt + PW'(w_pop);
            r_rd_level <= w_wbin_s - r_pop_cnt;
        end
    end

    // Shift-style buffer: entry 0 is always the head presented on m_data.
    always_ff @(posedge rd_clk or negedge rrstn) begin
        if (!rrstn) begin
            r_count <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case ({w_load, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf[0] <= bus.ram_rdata;
                    end else begin
                        r_buf[1] <= bus.ram_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf[0] <= bus.ram_rdata;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= bus.ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_rd    = w_issue;
    assign bus.ram_raddr = r_rbin[AW-1:0];
    assign bus.m_valid   = (r_count != 2'd0);
    assign bus.m_data    = r_buf[0];
    assign empty         = (r_count == 2'd0);
    assign rptr_gray     = r_rptr_gray;
    assign rd_level      = r_rd_level;
endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_rd_ctrl
//  Purpose  : Self-checking bench for the FIFO read-domain controller
//  Revision : 1.0  initial release
// ============================================================================
module tb_async_fifo_rd_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 1 << PW;

    logic          rd_clk = 1'b0;
    logic          rrstn;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_gray;
    logic          empty;
    logic [AW:0]   rd_level;

    async_fifo_rd_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    async_fifo_rd_ctrl #(.DW(DW), .AW(AW), .SYNC_STAGES(2)) dut (
        .rd_clk    (rd_clk),
        .rrstn     (rrstn),
        .wptr_gray (wptr_gray),
        .rptr_gray (rptr_gray),
        .empty     (empty),
        .rd_level  (rd_level),
        .bus       (bus)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural RAM with one cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge rd_clk) begin
        if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    // Reference model: every written word must pop out in order, exactly once.
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] raddr_log [$];
    int unsigned   wcount;
    int unsigned   rd_issued;
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;

    function automatic int unsigned gray(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcount % DEPTH] = d;
        exp_q.push_back(d);
        wcount++;
        wptr_gray = PW'(gray(wcount % PMOD));
    endtask

    always @(negedge rd_clk) begin
        if (rrstn === 1'b1) begin
            if (bus.ram_rd) begin
                check("raddr", 32'(bus.ram_raddr), rd_issued % DEPTH);
                check("no_overread", 32'(rd_issued < wcount), 32'd1);
                raddr_log.push_back(bus.ram_raddr);
                rd_issued++;
            end
            check("empty_vs_valid", 32'(empty), 32'(!bus.m_valid));
            if (bus.m_valid && bus.m_ready) begin
                check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("pop_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int rd_cnt, rd_runs, v_cnt, v_runs, need, base;
        logic prev_rd, prev_v;
        wcount = 0;
        rd_issued = 0;
        bus.m_ready = 1'b0;
        wptr_gray = '0;
        rrstn = 1'b0;

        // Reset held with a toggling write pointer.
        for (int i = 0; i < 6; i++) begin
            wptr_gray = (i % 2 == 1) ? 11'h005 : 11'h000;
            tick();
            check("rst_m_valid", 32'(bus.m_valid), 32'd0);
            check("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
            check("rst_rptr", 32'(rptr_gray), 32'd0);
            check("rst_level", 32'(rd_level), 32'd0);
            check("rst_m_data", 32'(bus.m_data), 32'd0);
        end
        wptr_gray = '0;
        rrstn = 1'b1;
        repeat (3) tick();
        check("idle_empty", 32'(empty), 32'd1);

        // Single word latency.
        write_word(8'hA5);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("lat_valid_e%0d", k), 32'(bus.m_valid), 32'(k == 4));
            check($sformatf("lat_ram_rd_e%0d", k), 32'(bus.ram_rd), 32'(k == 2));
        end
        check("single_data", 32'(bus.m_data), 32'hA5);
        bus.m_ready = 1'b1;
        tick();
        check("single_empty", 32'(empty), 32'd1);
        check("single_rptr", 32'(rptr_gray), 32'h001);

        // Burst throughput.
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        rd_cnt = 0; rd_runs = 0; v_cnt = 0; v_runs = 0; prev_rd = 0; prev_v = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ram_rd) begin rd_cnt++; if (!prev_rd) rd_runs++; end
            if (bus.m_valid) begin v_cnt++; if (!prev_v) v_runs++; end
            prev_rd = bus.ram_rd;
            prev_v  = bus.m_valid;
        end
        check("burst_rd_cnt", 32'(rd_cnt), 32'd8);
        check("burst_rd_runs", 32'(rd_runs), 32'd1);
        check("burst_valid_cnt", 32'(v_cnt), 32'd8);
        check("burst_valid_runs", 32'(v_runs), 32'd1);

        // Backpressure.
        bus.m_ready = 1'b0;
        base = rd_issued;
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        repeat (12) tick();
        check("bp_reads", 32'(rd_issued - base), 32'd2);
        check("bp_head", 32'(bus.m_data), 32'h10);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_level", 32'(rd_level), 32'd8);
        bus.m_ready = 1'b1;
        repeat (16) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_level_after", 32'(rd_level), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() < 64) repeat ($urandom_range(0, 3)) write_word(8'($urandom));
            tick();
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        repeat (6) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_level", 32'(rd_level), 32'd0);
        check("rand_rptr", 32'(rptr_gray), gray(wcount % PMOD));

        // Advance both pointers to 0x3FE, then cross the address wrap.
        need = int'((32'h3FE + PMOD - (wcount % PMOD)) % PMOD);
        for (int i = 0; i < 5000 && need > 0; i++) begin
            if (exp_q.size() < 32) begin
                for (int j = 0; j < 4 && need > 0; j++) begin
                    write_word(8'($urandom));
                    need--;
                end
            end
            tick();
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        repeat (6) tick();
        check("wrap_pre_rptr", 32'(rptr_gray), gray(32'h3FE));
        check("wrap_pre_drained", 32'(exp_q.size()), 32'd0);
        raddr_log.delete();
        for (int i = 0; i < 4; i++) write_word(8'($urandom));
        rd_runs = 0; prev_rd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.ram_rd && !prev_rd) rd_runs++;
            prev_rd = bus.ram_rd;
        end
        check("wrap_nreads", 32'(raddr_log.size()), 32'd4);
        check("wrap_runs", 32'(rd_runs), 32'd1);
        if (raddr_log.size() == 4) begin
            check("wrap_addr0", 32'(raddr_log[0]), 32'h3FE);
            check("wrap_addr1", 32'(raddr_log[1]), 32'h3FF);
            check("wrap_addr2", 32'(raddr_log[2]), 32'h000);
            check("wrap_addr3", 32'(raddr_log[3]), 32'h001);
        end
        check("wrap_rptr", 32'(rptr_gray), gray(32'h402));

        // Asynchronous reset in the middle of a backpressured transfer.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'($urandom));
        repeat (6) tick();
        check("mid_pre_valid", 32'(bus.m_valid), 32'd1);
        #2;
        rrstn = 1'b0;
        #1;
        check("mid_valid", 32'(bus.m_valid), 32'd0);
        check("mid_ram_rd", 32'(bus.ram_rd), 32'd0);
        check("mid_rptr", 32'(rptr_gray), 32'd0);
        check("mid_level", 32'(rd_level), 32'd0);
        check("mid_raddr", 32'(bus.ram_raddr), 32'd0);
        exp_q.delete();
        wcount = 0;
        rd_issued = 0;
        wptr_gray = '0;
        tick();
        tick();
        rrstn = 1'b1;
        repeat (3) tick();
        check("post_rst_empty", 32'(empty), 32'd1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) write_word(8'($urandom));
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
